// File: rtl/fp_argmax_stream_pkg.sv
// fp_defs: shared float helpers for the RL datapath.
// Holds the word/index width helpers plus NaN detection and the total-order key, so every
// block that ranks logits uses the same ordering. Values are passed zero-extended to KeyW bits.
package fp_defs;

    localparam int unsigned KeyW = 64;

    function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned fra_w);
        return exp_w + fra_w + 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : unsigned'($clog2(n));
    endfunction

    // Exponent all ones with a nonzero fraction.
    function automatic logic is_nan(input logic [KeyW-1:0] x, input int unsigned exp_w,
                                    input int unsigned fra_w);
        logic [KeyW-1:0] fra_mask;
        logic [KeyW-1:0] exp_mask;
        fra_mask = (KeyW'(1) << fra_w) - KeyW'(1);
        exp_mask = ((KeyW'(1) << exp_w) - KeyW'(1)) << fra_w;
        return ((x & exp_mask) == exp_mask) && ((x & fra_mask) != '0);
    endfunction

    // Unsigned key whose integer order matches float order. Negative zero is folded onto
    // positive zero so the two compare equal.
    function automatic logic [KeyW-1:0] order_key(input logic [KeyW-1:0] x,
                                                  input int unsigned exp_w,
                                                  input int unsigned fra_w);
        logic [KeyW-1:0] mag_mask;
        logic [KeyW-1:0] top;
        logic [KeyW-1:0] mag;
        mag_mask = (KeyW'(1) << (exp_w + fra_w)) - KeyW'(1);
        top      = KeyW'(1) << (exp_w + fra_w);
        mag      = x & mag_mask;
        if (((x & top) != '0) && (mag != '0)) begin
            return ~mag & mag_mask;
        end
        return mag | top;
    endfunction

endpackage

// File: rtl/fp_argmax_stream_if.sv
// fp_argmax_stream_if: logit input stream and argmax result stream.
// slave  : block side (consumes s_axis_*, produces m_axis_*).
// master : producer/consumer side (drives s_axis_* and m_axis_tready).
interface fp_argmax_stream_if
    import fp_defs::*;
#(
    parameter int unsigned EXP = 5,
    parameter int unsigned FRA = 10,
    parameter int unsigned N   = 8
) ();
    localparam int unsigned W    = word_w(EXP, FRA);
    localparam int unsigned IDXW = idx_w(N);

    logic [W-1:0]    s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [IDXW-1:0] m_axis_index;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tie;
    logic            m_axis_nan;
    logic            m_axis_err;
    logic            m_axis_tvalid;
    logic            m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_index, m_axis_tdata, m_axis_tie, m_axis_nan, m_axis_err,
               m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_index, m_axis_tdata, m_axis_tie, m_axis_nan, m_axis_err,
               m_axis_tvalid
    );
endinterface

// File: rtl/fp_argmax_stream_total_cmp.sv
// fp_total_cmp: combinational total-order compare of two floats.
// Ports: a, b (W-bit words); gt = a > b, eq = a == b (+0 equals -0). Not meaningful for NaN.
module fp_total_cmp
    import fp_defs::*;
#(
    parameter int unsigned EXP = 5,
    parameter int unsigned FRA = 10
) (
    input  logic [word_w(EXP, FRA)-1:0] a,
    input  logic [word_w(EXP, FRA)-1:0] b,
    output logic                        gt,
    output logic                        eq
);
    logic [KeyW-1:0] key_a;
    logic [KeyW-1:0] key_b;

    always_comb begin
        key_a = order_key(KeyW'(a), EXP, FRA);
        key_b = order_key(KeyW'(b), EXP, FRA);
        gt    = key_a > key_b;
        eq    = key_a == key_b;
    end
endmodule

// File: rtl/fp_argmax_stream.sv
// fp_argmax_stream: streaming argmax over N logits per frame.
// Ports: aclk clock; aresetn synchronous active-high reset; axis (slave modport) carries the
// logit input stream (tdata/tvalid/tready/tlast) and the registered result stream
// (index/tdata/tie/nan/err/tvalid/tready). The beat counter alone delimits frames.
module fp_argmax_stream
    import fp_defs::*;
#(
    parameter int unsigned EXP      = 5,
    parameter int unsigned FRA      = 10,
    parameter int unsigned N        = 8,
    parameter int unsigned TIE_LAST = 0
) (
    input logic               aclk,
    input logic               aresetn,
    fp_argmax_stream_if.slave axis
);
    localparam int unsigned     W       = word_w(EXP, FRA);
    localparam int unsigned     IDXW    = idx_w(N);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(N - 1);

    logic [IDXW-1:0] cnt_q;
    logic [W-1:0]    best_q, best_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            tie_q, tie_d;
    logic            nan_q, nan_d;
    logic            err_q, err_d;
    logic            have_q, have_d;

    logic [W-1:0]    out_data_q;
    logic [IDXW-1:0] out_idx_q;
    logic            out_tie_q, out_nan_q, out_err_q, out_valid_q;

    logic [W-1:0] beat;
    logic         beat_nan, beat_gt, beat_eq, last_pos;
    logic         s_ready, accept, close;

    assign beat = axis.s_axis_tdata;

    fp_total_cmp #(
        .EXP(EXP),
        .FRA(FRA)
    ) u_cmp (
        .a (beat),
        .b (best_q),
        .gt(beat_gt),
        .eq(beat_eq)
    );

    always_comb begin
        beat_nan = is_nan(KeyW'(beat), EXP, FRA);
        last_pos = cnt_q == LastIdx;
        s_ready  = !aresetn && (!out_valid_q || axis.m_axis_tready);
        accept   = axis.s_axis_tvalid && s_ready;
        close    = accept && last_pos;

        best_d = best_q;
        idx_d  = idx_q;
        tie_d  = tie_q;
        nan_d  = nan_q;
        err_d  = err_q;
        have_d = have_q;
        if (accept) begin
            nan_d = nan_q | beat_nan;
            err_d = err_q | (axis.s_axis_tlast != last_pos);
            if (!beat_nan) begin
                if (!have_q || beat_gt) begin
                    best_d = beat;
                    idx_d  = cnt_q;
                    tie_d  = 1'b0;
                    have_d = 1'b1;
                end else if (beat_eq) begin
                    tie_d = 1'b1;
                    if (TIE_LAST != 0) begin
                        idx_d = cnt_q;
                    end
                end
            end else if (!have_q && (cnt_q == '0)) begin
                // Park beat 0 so an all-NaN frame reports it; have stays 0 so any later
                // non-NaN beat still takes over.
                best_d = beat;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            cnt_q       <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            tie_q       <= 1'b0;
            nan_q       <= 1'b0;
            err_q       <= 1'b0;
            have_q      <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_tie_q   <= 1'b0;
            out_nan_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= last_pos ? '0 : cnt_q + IDXW'(1);
            end
            if (close) begin
                best_q      <= '0;
                idx_q       <= '0;
                tie_q       <= 1'b0;
                nan_q       <= 1'b0;
                err_q       <= 1'b0;
                have_q      <= 1'b0;
                out_data_q  <= best_d;
                out_idx_q   <= idx_d;
                out_tie_q   <= tie_d;
                out_nan_q   <= nan_d;
                out_err_q   <= err_d;
                out_valid_q <= 1'b1;
            end else begin
                best_q <= best_d;
                idx_q  <= idx_d;
                tie_q  <= tie_d;
                nan_q  <= nan_d;
                err_q  <= err_d;
                have_q <= have_d;
                if (axis.m_axis_tready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_index  = out_idx_q;
    assign axis.m_axis_tdata  = out_data_q;
    assign axis.m_axis_tie    = out_tie_q;
    assign axis.m_axis_nan    = out_nan_q;
    assign axis.m_axis_err    = out_err_q;
    assign axis.m_axis_tvalid = out_valid_q;
endmodule

// File: tb/tb_fp_argmax_stream.sv
// Bench for fp_argmax_stream: two N=4 instances (lowest / highest tie index) fed the same
// stream. Table vectors, hand sequences (stall, mid-frame reset) and random frames checked
// against a real-valued reference model.
module tb_fp_argmax_stream;
    localparam int unsigned EXP = 5;
    localparam int unsigned FRA = 10;
    localparam int unsigned N   = 4;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] data;
        logic        tie;
        logic        nan;
        logic        err;
    } res_t;

    typedef struct {
        logic [15:0] beats [4];
        logic [3:0]  tl;
        res_t        e0;
        res_t        e1;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] in_data;
    logic        in_valid, in_last, out_ready;
    bit          rand_ready;

    int n_tests = 0;
    int n_fail  = 0;

    res_t exp0[$];
    res_t exp1[$];

    always #5 aclk = ~aclk;

    fp_argmax_stream_if #(.EXP(EXP), .FRA(FRA), .N(N)) bus0 ();
    fp_argmax_stream_if #(.EXP(EXP), .FRA(FRA), .N(N)) bus1 ();

    assign bus0.s_axis_tdata  = in_data;
    assign bus0.s_axis_tvalid = in_valid;
    assign bus0.s_axis_tlast  = in_last;
    assign bus0.m_axis_tready = out_ready;
    assign bus1.s_axis_tdata  = in_data;
    assign bus1.s_axis_tvalid = in_valid;
    assign bus1.s_axis_tlast  = in_last;
    assign bus1.m_axis_tready = out_ready;

    fp_argmax_stream #(.EXP(EXP), .FRA(FRA), .N(N), .TIE_LAST(0)) dut0 (
        .aclk   (aclk),
        .aresetn(aresetn),
        .axis   (bus0)
    );

    fp_argmax_stream #(.EXP(EXP), .FRA(FRA), .N(N), .TIE_LAST(1)) dut1 (
        .aclk   (aclk),
        .aresetn(aresetn),
        .axis   (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic res_t mk(input int idx, input logic [15:0] d, input bit t, input bit n,
                                input bit e);
        res_t r;
        r.idx  = 2'(idx);
        r.data = d;
        r.tie  = t;
        r.nan  = n;
        r.err  = e;
        return r;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit h_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1f) && (v[9:0] != '0);
    endfunction

    function automatic real h_val(input logic [15:0] v);
        real m;
        int  sh;
        int  e;
        e = int'(v[14:10]);
        if (e == 31) begin
            m  = 1.0e300;
            sh = 0;
        end else if (e == 0) begin
            m  = real'(int'(v[9:0]));
            sh = -24;
        end else begin
            m  = real'(1024 + int'(v[9:0]));
            sh = e - 25;
        end
        while (sh > 0) begin
            m = m * 2.0;
            sh--;
        end
        while (sh < 0) begin
            m = m / 2.0;
            sh++;
        end
        return v[15] ? -m : m;
    endfunction

    function automatic res_t model(input logic [15:0] b [4], input logic [3:0] tl,
                                   input bit last_rule);
        res_t r;
        bit   found;
        real  best, v;
        int   first, last, n_eq;
        r     = '0;
        found = 0;
        best  = 0.0;
        first = 0;
        last  = 0;
        n_eq  = 0;
        for (int i = 0; i < 4; i++) begin
            if (h_nan(b[i])) begin
                r.nan = 1'b1;
            end else begin
                v = h_val(b[i]);
                if (!found || v > best) begin
                    best  = v;
                    first = i;
                    last  = i;
                    n_eq  = 1;
                    found = 1;
                end else if (v == best) begin
                    last = i;
                    n_eq++;
                end
            end
        end
        r.err = (tl != 4'b1000);
        if (found) begin
            r.idx  = 2'(last_rule ? last : first);
            r.data = b[first];
            r.tie  = n_eq > 1;
        end else begin
            r.data = b[0];
        end
        return r;
    endfunction

    // ---------------- output monitors ----------------
    res_t prev0, prev1, cur0, cur1;
    bit   hold0, hold1;

    always @(negedge aclk) begin
        if (aresetn) begin
            hold0 = 0;
        end else if (bus0.m_axis_tvalid) begin
            cur0 = mk(int'(bus0.m_axis_index), bus0.m_axis_tdata, bus0.m_axis_tie,
                      bus0.m_axis_nan, bus0.m_axis_err);
            if (hold0) check("hold0", 32'(cur0), 32'(prev0));
            if (out_ready) begin
                if (exp0.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL res0: got unexpected result %h, expected none", cur0);
                end else begin
                    check("res0", 32'(cur0), 32'(exp0.pop_front()));
                end
                hold0 = 0;
            end else begin
                hold0 = 1;
                prev0 = cur0;
            end
        end else begin
            hold0 = 0;
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            hold1 = 0;
        end else if (bus1.m_axis_tvalid) begin
            cur1 = mk(int'(bus1.m_axis_index), bus1.m_axis_tdata, bus1.m_axis_tie,
                      bus1.m_axis_nan, bus1.m_axis_err);
            if (hold1) check("hold1", 32'(cur1), 32'(prev1));
            if (out_ready) begin
                if (exp1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL res1: got unexpected result %h, expected none", cur1);
                end else begin
                    check("res1", 32'(cur1), 32'(exp1.pop_front()));
                end
                hold1 = 0;
            end else begin
                hold1 = 1;
                prev1 = cur1;
            end
        end else begin
            hold1 = 0;
        end
    end

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 just after the beat is taken.
    task automatic send_beat(input logic [15:0] d, input logic l);
        bit acc;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int g = 0; g < 300; g++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus0.s_axis_tready;
            @(posedge aclk);
            #1;
            if (acc) return;
        end
        $display("FAIL send_beat: got no s_axis_tready within 300 cycles, expected acceptance");
        n_fail++;
        $fatal(1, "input stalled");
    endtask

    task automatic send_frame(input vec_t v, input bit chk_lat);
        exp0.push_back(v.e0);
        exp1.push_back(v.e1);
        for (int i = 0; i < 4; i++) begin
            if (chk_lat && i == 3) check("pre_close_valid", 32'(bus0.m_axis_tvalid), 32'd0);
            send_beat(v.beats[i], v.tl[i]);
        end
        if (chk_lat) check("latency_valid", 32'(bus0.m_axis_tvalid), 32'd1);
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        rand_ready = 0;
        out_ready  = 1'b1;
        for (int g = 0; g < 50; g++) begin
            if (exp0.size() == 0 && exp1.size() == 0) break;
            @(posedge aclk);
            #1;
        end
        repeat (3) @(posedge aclk);
        #1;
        check("drain0", 32'(exp0.size()), 32'd0);
        check("drain1", 32'(exp1.size()), 32'd0);
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        tbl[0] = '{beats: '{16'h3C00, 16'h4000, 16'hC000, 16'h3800}, tl: 4'b1000,
                   e0: mk(1, 16'h4000, 0, 0, 0), e1: mk(1, 16'h4000, 0, 0, 0)};
        tbl[1] = '{beats: '{16'h4000, 16'h3C00, 16'h4000, 16'h0000}, tl: 4'b1000,
                   e0: mk(0, 16'h4000, 1, 0, 0), e1: mk(2, 16'h4000, 1, 0, 0)};
        tbl[2] = '{beats: '{16'h8000, 16'h0000, 16'hBC00, 16'hFC00}, tl: 4'b1000,
                   e0: mk(0, 16'h8000, 1, 0, 0), e1: mk(1, 16'h8000, 1, 0, 0)};
        tbl[3] = '{beats: '{16'h7E00, 16'hC000, 16'h7E00, 16'hC400}, tl: 4'b1000,
                   e0: mk(1, 16'hC000, 0, 1, 0), e1: mk(1, 16'hC000, 0, 1, 0)};
        tbl[4] = '{beats: '{16'h7E00, 16'h7C01, 16'hFE00, 16'h7FFF}, tl: 4'b1000,
                   e0: mk(0, 16'h7E00, 0, 1, 0), e1: mk(0, 16'h7E00, 0, 1, 0)};
        tbl[5] = '{beats: '{16'h3C00, 16'hBC00, 16'h4200, 16'h4100}, tl: 4'b0010,
                   e0: mk(2, 16'h4200, 0, 0, 1), e1: mk(2, 16'h4200, 0, 0, 1)};
        tbl[6] = '{beats: '{16'h7C00, 16'hFC00, 16'h7BFF, 16'h7C00}, tl: 4'b1000,
                   e0: mk(0, 16'h7C00, 1, 0, 0), e1: mk(3, 16'h7C00, 1, 0, 0)};

        // Reset state.
        aresetn    = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        rand_ready = 0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", 32'(bus0.s_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(bus0.m_axis_tvalid), 32'd0);
        check("rst_m_tdata", 32'(bus0.m_axis_tdata), 32'd0);
        check("rst_m_flags", 32'({bus0.m_axis_index, bus0.m_axis_tie, bus0.m_axis_nan,
                                  bus0.m_axis_err}), 32'd0);
        aresetn = 1'b0;
        #1;
        check("rel_s_tready", 32'(bus0.s_axis_tready), 32'd1);

        // Table vectors, back to back with the consumer always ready.
        foreach (tbl[i]) send_frame(tbl[i], 1);
        drain();

        // Stall: result held for 5 cycles, input blocked, then no-bubble resume.
        out_ready = 1'b0;
        send_frame(tbl[0], 0);
        check("stall_valid", 32'(bus0.m_axis_tvalid), 32'd1);
        exp0.push_back(tbl[1].e0);
        exp1.push_back(tbl[1].e1);
        in_data  = tbl[1].beats[0];
        in_last  = tbl[1].tl[0];
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_s_tready", 32'(bus0.s_axis_tready), 32'd0);
            @(posedge aclk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("resume_s_tready", 32'(bus0.s_axis_tready), 32'd1);
        for (int i = 0; i < 4; i++) send_beat(tbl[1].beats[i], tbl[1].tl[i]);
        check("resume_valid", 32'(bus0.m_axis_tvalid), 32'd1);
        drain();

        // Mid-frame reset: two beats taken, reset arrives with beat 2 presented.
        send_beat(16'h5000, 1'b0);
        send_beat(16'h5400, 1'b0);
        in_data = 16'h5800;
        aresetn = 1'b1;
        #1;
        check("mid_rst_s_tready", 32'(bus0.s_axis_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("mid_rst_valid", 32'(bus0.m_axis_tvalid), 32'd0);
        aresetn  = 1'b0;
        in_valid = 1'b0;
        @(posedge aclk);
        #1;
        check("post_rst_valid", 32'(bus0.m_axis_tvalid), 32'd0);
        send_frame(tbl[2], 0);
        drain();

        // Random frames against the reference model, random consumer back-pressure.
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: rv.beats[i] = 16'h0000;
                    1: rv.beats[i] = 16'($urandom);
                    2: begin
                        case ($urandom_range(0, 5))
                            0: rv.beats[i] = 16'h8000;
                            1: rv.beats[i] = 16'h7C00;
                            2: rv.beats[i] = 16'hFC00;
                            3: rv.beats[i] = 16'h7E00;
                            4: rv.beats[i] = 16'hBC00;
                            default: rv.beats[i] = 16'h3C00;
                        endcase
                    end
                    default: rv.beats[i] = 16'($urandom);
                endcase
            end
            rv.tl = 4'b1000;
            if ($urandom_range(0, 7) == 0) rv.tl[$urandom_range(0, 3)] ^= 1'b1;
            rv.e0 = model(rv.beats, rv.tl, 0);
            rv.e1 = model(rv.beats, rv.tl, 1);
            send_frame(rv, 0);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge aclk);
                #1;
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_argmax_stream.md
# fp_argmax_stream

N-channel streaming argmax over half-precision-style floats (EXP/FRA parametrised) for the RL action-selection path. Generalises the fixed two-way softmax comparator: softmax is monotonic, so the block compares the logits directly and skips the exp/div chain. It accepts one logit per beat over an AXI-Stream input and counts N beats per frame. Per frame it emits the winning index, the max value, and tie, NaN and framing flags through a registered, back-pressurable output.

## Interface
- EXP, 5: exponent width.
- FRA, 10: fraction width. The word is W = EXP+FRA+1 bits.
- N, 8: logits per frame. N ≥ 2.
- TIE_LAST, 0: tie-break rule. 0 keeps the lowest equal index; 1 keeps the highest.
- IDXW, derived: ceil(log2 N), minimum 1.

Ports:
- aclk  in  1  clock; everything is on the rising edge.
- aresetn  in  1  reset. Synchronous and active-high, despite the suffix.
- s_axis_tdata  in  W  logit (sign, exponent, fraction).
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted.
- s_axis_tlast  in  1  marks the producer's last beat of a frame; checked only.
- m_axis_index  out  IDXW  argmax position within the frame.
- m_axis_tdata  out  W  max value.
- m_axis_tie  out  1  max value occurred at two or more indices.
- m_axis_nan  out  1  at least one NaN in the frame.
- m_axis_err  out  1  tlast position did not match beat N-1.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accepts the result.

## Operation
- Beat accepted = s_axis_tvalid & s_axis_tready.
- s_axis_tready = !m_axis_tvalid | m_axis_tready.
- Beat counter cnt runs 0..N-1 and wraps to 0 after beat N-1. The counter is authoritative for frame boundaries; tlast never ends a frame.
- Accumulator registers: best value, best index, tie, nan, err, plus a "have" flag. have=0 means no non-NaN beat has been seen yet in this frame.
- Comparison uses a total-order key:
  - positive value: key = {1, magnitude}.
  - negative value: key = {0, ~magnitude}.
  - -0 and +0 compare equal. ±Inf compare normally.
- NaN means exponent all ones and fraction ≠ 0. A NaN beat sets nan and never becomes best.
- Per accepted non-NaN beat x at cnt:
  - If have=0, or x > best: load best=x, index=cnt, tie=0.
  - If x == best: tie=1, and when TIE_LAST=1 also index=cnt.
  - If x < best: no change.
- err is set on any beat where tlast ≠ (cnt == N-1).
- Close (beat with cnt == N-1 accepted):
  - Load the output registers with the accumulator state including this beat's update.
  - Clear the accumulator in the same cycle.
  - If every beat in the frame was NaN: index=0, tdata = beat 0's value, nan=1, tie=0.
- Output register: m_axis_tvalid falls on handshake unless a new close happens in the same cycle. In that case the new result loads and valid stays 1.
- Reset:
  - All outputs 0, including m_axis_tvalid.
  - s_axis_tready is 0 while aresetn=1 and 1 on the first cycle after release.
  - Accumulator and cnt clear.
  - A frame in progress is discarded; no partial result is emitted.

## Timing
- Latency: m_axis_tvalid rises 1 cycle after the closing beat is accepted.
- Throughput: 1 beat per cycle sustained with m_axis_tready=1, so frames run back to back with no bubble.
- Stall: with m_axis_tvalid=1 and m_axis_tready=0, s_axis_tready=0.
- Output data is held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous output handshake and new close in one cycle: no bubble, the new result loads.

## Structure
- Shared package fp_defs holds:
  - the W/IDXW width helpers;
  - the is_nan and total-order key functions, so other RL blocks use identical ordering.
- Sub-module fp_total_cmp: combinational. Inputs a and b; outputs gt and eq on the ordering keys. It is instantiated once.
- The top holds the counter, accumulator and output register slice. No FSM beyond have/tvalid.

## Test plan
- N=4, frame {0x3C00, 0x4000, 0xC000, 0x3800} with correct tlast → index=1, tdata=0x4000, tie=0, nan=0, err=0, valid 1 cycle after beat 3.
- N=4, frame {0x4000, 0x3C00, 0x4000, 0x0000}:
  - TIE_LAST=0 → index=0, tie=1.
  - TIE_LAST=1 → index=2.
- N=4, frame {0x8000, 0x0000, 0xBC00, 0xFC00} → tie=1, index=0, tdata=0x8000.
- N=4, frame {0x7E00, 0xC000, 0x7E00, 0xC400} → index=1, nan=1. All-NaN frame → index=0, nan=1.
- Two back-to-back frames with m_axis_tready=0 for 5 cycles after the first result:
  - s_axis_tready drops exactly while the output is full.
  - No result is lost or duplicated.
  - Second result follows the first handshake with no bubble.
- tlast asserted on beat 1 of N=4 → err=1 and the frame still closes at beat 3. aresetn=1 mid-frame at beat 2 → no output; the next full frame yields the correct result.
